// File: rtl/mem_interconnect_pkg.sv
// mem_interconnect_pkg: shared widths, FSM state type and sizing helper
package mem_interconnect_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int ERR_CNT_W  = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_region_decoder.sv
// mem_region_decoder: address to target index; lowest hitting region wins
module mem_region_decoder
    import mem_interconnect_pkg::*;
#(
    parameter int                        N_TGT  = 2,
    parameter int                        ADDR_W = DEF_ADDR_W,
    parameter logic [N_TGT*ADDR_W-1:0]   BASE   = {16'h8000, 16'h0000},
    parameter logic [N_TGT*ADDR_W-1:0]   MASK   = {16'hFF00, 16'hC000}
) (
    input  logic [ADDR_W-1:0]            addr,
    output logic                         hit,
    output logic [idx_w(N_TGT)-1:0]      idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--)
            if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = idx_w(N_TGT)'(i);
            end
    end
endmodule

// File: rtl/mem_interconnect.sv
// mem_interconnect: single-master to N_TGT-target bridge with region decode,
// per-access timeout and sticky error reporting.
module mem_interconnect
    import mem_interconnect_pkg::*;
#(
    parameter int                        ADDR_W      = DEF_ADDR_W,
    parameter int                        DATA_W      = DEF_DATA_W,
    parameter int                        N_TGT       = 2,
    parameter logic [N_TGT*ADDR_W-1:0]   REGION_BASE = {16'h8000, 16'h0000},
    parameter logic [N_TGT*ADDR_W-1:0]   REGION_MASK = {16'hFF00, 16'hC000},
    parameter int                        TIMEOUT     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_be,
    output logic                         resp_valid,
    output logic [DATA_W-1:0]            resp_rdata,
    output logic                         resp_err,
    output logic [N_TGT-1:0]             tgt_sel,
    output logic                         tgt_we,
    output logic [ADDR_W-1:0]            tgt_addr,
    output logic [DATA_W-1:0]            tgt_wdata,
    output logic [DATA_W/8-1:0]          tgt_be,
    input  logic [N_TGT*DATA_W-1:0]      tgt_rdata,
    input  logic [N_TGT-1:0]             tgt_ready,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [ERR_CNT_W-1:0]         err_count
);
    localparam int IDX_W = idx_w(N_TGT);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                 r_state, w_next;
    logic                   r_we, r_err;
    logic [ADDR_W-1:0]      r_addr, r_err_addr;
    logic [DATA_W-1:0]      r_wdata, r_rdata;
    logic [DATA_W/8-1:0]    r_be;
    logic [IDX_W-1:0]       r_idx, w_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [ERR_CNT_W-1:0]   r_err_count;
    logic                   w_hit, w_hs, w_rdy, w_tmo, w_err_evt;
    logic [DATA_W-1:0]      w_rd [N_TGT];

    for (genvar g = 0; g < N_TGT; g++) begin : g_rd
        assign w_rd[g] = tgt_rdata[g*DATA_W +: DATA_W];
    end

    mem_region_decoder #(
        .N_TGT (N_TGT),
        .ADDR_W(ADDR_W),
        .BASE  (REGION_BASE),
        .MASK  (REGION_MASK)
    ) u_dec (
        .addr(req_addr),
        .hit (w_hit),
        .idx (w_idx)
    );

    // req_ready is gated by rst_n so it reads 0 throughout reset
    assign req_ready = rst_n && (r_state == IDLE);
    assign w_hs      = req_valid && req_ready;
    assign w_rdy     = (r_state == ACCESS) && tgt_ready[r_idx];
    assign w_tmo     = (r_state == ACCESS) && !tgt_ready[r_idx] && (r_cnt == CNT_W'(TIMEOUT));
    assign w_err_evt = (w_hs && !w_hit) || w_tmo;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hs ? (w_hit ? ACCESS : RESP) : IDLE;
            ACCESS:  w_next = (w_rdy || w_tmo) ? RESP : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        tgt_sel = '0;
        if (r_state == ACCESS)
            tgt_sel[r_idx] = 1'b1;
    end

    assign resp_valid = (r_state == RESP);
    assign resp_rdata = resp_valid ? r_rdata : '0;
    assign resp_err   = resp_valid && r_err;
    assign tgt_we     = r_we;
    assign tgt_addr   = r_addr;
    assign tgt_wdata  = r_wdata;
    assign tgt_be     = r_be;
    assign err_addr   = r_err_addr;
    assign err_count  = r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            if (w_hs) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_idx   <= w_idx;
                r_cnt   <= CNT_W'(1);
                r_rdata <= '0;
                r_err   <= !w_hit;
            end
            // ready on the final counted cycle still wins over the timeout
            if (w_rdy) begin
                r_rdata <= r_we ? '0 : w_rd[r_idx];
                r_err   <= 1'b0;
            end else if (w_tmo) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end else if (r_state == ACCESS) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
            if (w_err_evt) begin
                r_err_addr <= w_hs ? req_addr : r_addr;
                if (r_err_count != '1)
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_interconnect.sv
// tb_mem_interconnect: directed transactions against a per-cycle expectation
// model derived from the decode map, latency and timeout rules.
module tb_mem_interconnect;
    localparam int AW = 16, DW = 32, NT = 2, TO = 16;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [DW-1:0]   req_wdata = '0;
    logic [DW/8-1:0] req_be = '0;
    logic            req_ready, resp_valid, resp_err, tgt_we;
    logic [DW-1:0]   resp_rdata, tgt_wdata;
    logic [NT-1:0]   tgt_sel;
    logic [AW-1:0]   tgt_addr, err_addr;
    logic [DW/8-1:0] tgt_be;
    logic [NT*DW-1:0] tgt_rdata = '0;
    logic [NT-1:0]   tgt_ready = '0;
    logic [7:0]      err_count;

    always #5 clk = ~clk;

    mem_interconnect dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .tgt_sel(tgt_sel), .tgt_we(tgt_we), .tgt_addr(tgt_addr),
        .tgt_wdata(tgt_wdata), .tgt_be(tgt_be), .tgt_rdata(tgt_rdata),
        .tgt_ready(tgt_ready), .err_addr(err_addr), .err_count(err_count)
    );

    int checks = 0, failures = 0;
    int cyc = 0, hs_cyc = 0, lat = 0;
    logic [DW-1:0] last_rdata = '0;

    logic            exp_ready = 1'b0, exp_rv = 1'b0, exp_err = 1'b0;
    logic [DW-1:0]   exp_rdata = '0;
    logic [NT-1:0]   exp_sel = '0;
    logic [7:0]      exp_cnt = '0;
    logic [AW-1:0]   exp_eaddr = '0;
    logic            chk_fields = 1'b1, exp_we = 1'b0;
    logic [AW-1:0]   exp_addr = '0;
    logic [DW-1:0]   exp_wdata = '0;
    logic [DW/8-1:0] exp_be = '0;

    // Memory map of the default parameters: RAM 0x0000-0x3FFF, IO 0x8000-0x80FF
    function automatic int decode(input logic [AW-1:0] a);
        if (a < 16'h4000) return 0;
        if (a >= 16'h8000 && a <= 16'h80FF) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (req_valid && req_ready) hs_cyc = cyc;
        if (resp_valid) begin
            lat = cyc - hs_cyc;
            last_rdata = resp_rdata;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        chk("resp_rdata", 64'(resp_rdata), exp_rv ? 64'(exp_rdata) : 64'd0);
        chk("resp_err", 64'(resp_err), 64'(exp_rv && exp_err));
        chk("tgt_sel", 64'(tgt_sel), 64'(exp_sel));
        chk("err_count", 64'(err_count), 64'(exp_cnt));
        chk("err_addr", 64'(err_addr), 64'(exp_eaddr));
        if (chk_fields) begin
            chk("tgt_we", 64'(tgt_we), 64'(exp_we));
            chk("tgt_addr", 64'(tgt_addr), 64'(exp_addr));
            chk("tgt_wdata", 64'(tgt_wdata), 64'(exp_wdata));
            chk("tgt_be", 64'(tgt_be), 64'(exp_be));
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] rd, output int t);
        t = decode(a);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_be = ~be;
        exp_ready = 1'b0;
        if (t >= 0) begin
            tgt_rdata = {NT{~rd}};
            tgt_rdata[t*DW +: DW] = rd;
            exp_we = we; exp_addr = a; exp_wdata = wd; exp_be = be;
            chk_fields = 1'b1;
            exp_sel = '0;
            exp_sel[t] = 1'b1;
        end
    endtask

    // dly: ACCESS cycle on which the selected target answers (0 = never)
    task automatic txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] be, input int dly, input logic [DW-1:0] rd);
        int t;
        bit ok;
        ok = 1'b0;
        issue(we, a, wd, be, rd, t);
        if (t >= 0) begin
            for (int k = 1; k <= TO; k++) begin
                tgt_ready = '0;
                tgt_ready[1-t] = 1'b1;
                if (k == dly) tgt_ready[t] = 1'b1;
                @(negedge clk);
                if (k == dly) begin ok = 1'b1; break; end
            end
            tgt_ready = '0; exp_sel = '0; chk_fields = 1'b0;
        end
        exp_rv = 1'b1;
        exp_err = !ok;
        exp_rdata = (ok && !we) ? rd : '0;
        if (!ok) begin
            exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
            exp_eaddr = a;
        end
        @(negedge clk);
        exp_rv = 1'b0; exp_ready = 1'b1;
    endtask

    task automatic abort_txn(input logic [AW-1:0] a);
        int t;
        issue(1'b0, a, 32'h0, 4'hF, 32'h5555AAAA, t);
        tgt_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_ready = 1'b0; exp_sel = '0; exp_cnt = '0; exp_eaddr = '0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0; chk_fields = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ready = 1'b1; chk_fields = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_ready = 1'b1; chk_fields = 1'b0;
        @(negedge clk);

        txn(1'b0, 16'h0010, 32'h0, 4'hF, 1, 32'hDEADBEEF);
        chk("read_rdata_lit", 64'(last_rdata), 64'hDEADBEEF);
        chk("read_latency", 64'(lat), 64'd2);

        txn(1'b1, 16'h8004, 32'h000000A5, 4'b0001, 3, 32'h12345678);
        chk("write_rdata_lit", 64'(last_rdata), 64'd0);
        chk("write_latency", 64'(lat), 64'd4);

        txn(1'b0, 16'h4000, 32'h0, 4'hF, 1, 32'h11111111);
        chk("miss_latency", 64'(lat), 64'd1);
        chk("miss_err_addr", 64'(err_addr), 64'h4000);
        chk("miss_err_count", 64'(err_count), 64'd1);

        txn(1'b0, 16'h0000, 32'h0, 4'hF, 0, 32'h0BAD0BAD);
        chk("timeout_latency", 64'(lat), 64'd17);
        chk("timeout_err_count", 64'(err_count), 64'd2);

        txn(1'b0, 16'h0000, 32'h0, 4'hF, 16, 32'h600DF00D);
        chk("ready_on_16_rdata", 64'(last_rdata), 64'h600DF00D);
        chk("ready_on_16_latency", 64'(lat), 64'd17);

        txn(1'b0, 16'h3FFC, 32'h0, 4'hF, 2, 32'hCAFEF00D);
        txn(1'b0, 16'h80FF, 32'h0, 4'hF, 1, 32'hA5A5A5A5);
        txn(1'b1, 16'h0100, 32'hFFEEDDCC, 4'b1010, 5, 32'h77777777);
        txn(1'b1, 16'h8100, 32'h12121212, 4'hF, 1, 32'h0);
        txn(1'b0, 16'hC000, 32'h0, 4'hF, 1, 32'h0);
        chk("misc_err_addr", 64'(err_addr), 64'hC000);

        abort_txn(16'h0040);
        chk("after_reset_count", 64'(err_count), 64'd0);
        txn(1'b0, 16'h0020, 32'h0, 4'hF, 1, 32'h13579BDF);
        chk("after_reset_rdata", 64'(last_rdata), 64'h13579BDF);

        for (int i = 0; i < 300; i++)
            txn(1'b0, 16'h4000 + 16'(i), 32'h0, 4'hF, 1, 32'h0);
        chk("sat_err_count", 64'(err_count), 64'd255);
        chk("sat_err_addr", 64'(err_addr), 64'h412B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
